// File: rtl/bcd_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter (reverse double-dabble).
// Optional input range checking is enabled with the BCD_RANGE_CHECK_EN macro.
package bcd_binary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W       = 4;
  localparam int BCD_ADJ_THRESHOLD = 8;
  localparam int BCD_ADJ_SUB       = 3;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_binary_if.sv
// Request/response bundle for bcd_binary.
// Handshake: start is sampled only while the converter is idle; busy is high from the
// accepting edge until the cycle after done; done is a one-cycle pulse when binary,
// overflow and error are valid, and those outputs hold until the next done.
interface bcd_binary_if #(
  parameter int DIGITS    = 3,
  parameter int BIN_WIDTH = 8
);
  logic                   start;
  logic [4*DIGITS-1:0]    bcd_in;
  logic [BIN_WIDTH-1:0]   binary;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic                   error;

  modport master (
    output start, bcd_in,
    input  binary, busy, done, overflow, error
  );

  modport slave (
    input  start, bcd_in,
    output binary, busy, done, overflow, error
  );
endinterface

// File: rtl/bcd_digit_adjust.sv
// One-digit correction step for reverse double-dabble: after a right shift, any digit
// of 8 or more carried a ten's worth of weight from above and is reduced by 3.
module bcd_digit_adjust
  import bcd_binary_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'(BCD_ADJ_THRESHOLD)) dout = din - 4'(BCD_ADJ_SUB);
  end

endmodule

// File: rtl/bcd_binary.sv
// Sequential BCD-to-binary converter, one shift per clock, saturating on overflow.
// Define BCD_RANGE_CHECK_EN to flag non-BCD digits on the error output.
module bcd_binary
  import bcd_binary_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int BIN_WIDTH = 8
) (
  input  logic   clock,
  input  logic   reset_n,
  bcd_binary_if.slave bus,
  output state_t dbg_state
);

  localparam int BW   = BCD_DIGIT_W * DIGITS;
  localparam int MAXW = (BW > BIN_WIDTH) ? BW : BIN_WIDTH;
  localparam int CW   = $clog2(BW + 1);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  state_t                 state;
  logic [BW-1:0]          bcd_reg;
  logic [BW-1:0]          bin_reg;
  logic [CW-1:0]          cnt;
  logic [BIN_WIDTH-1:0]   binary_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   ovf_r;

  logic [BW-1:0]          bcd_shift;
  logic [BW-1:0]          bcd_adj;
  logic [MAXW-1:0]        bin_ext;
  logic                   ovf;

  assign bcd_shift = {1'b0, bcd_reg[BW-1:1]};
  assign bin_ext   = MAXW'(bin_reg);
  // Any set bit above the output width means the value does not fit.
  assign ovf       = |(bin_ext >> BIN_WIDTH);

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (bcd_shift[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_RANGE_CHECK_EN
  logic bad_r;
  logic error_r;

  function automatic logic any_digit_bad(input logic [BW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) bad |= digit_invalid(v[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
    return bad;
  endfunction
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bcd_reg  <= '0;
      bin_reg  <= '0;
      cnt      <= '0;
      binary_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
`ifdef BCD_RANGE_CHECK_EN
      bad_r    <= 1'b0;
      error_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= bus.start;
          if (bus.start) begin
            bcd_reg <= bus.bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            state   <= SHIFT;
`ifdef BCD_RANGE_CHECK_EN
            bad_r   <= any_digit_bad(bus.bcd_in);
`endif
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= {bcd_reg[0], bin_reg[BW-1:1]};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
`ifdef BCD_RANGE_CHECK_EN
          if (bad_r) begin
            binary_r <= '0;
            ovf_r    <= 1'b0;
            error_r  <= 1'b1;
          end else begin
            binary_r <= ovf ? '1 : bin_ext[BIN_WIDTH-1:0];
            ovf_r    <= ovf;
            error_r  <= 1'b0;
          end
`else
          binary_r <= ovf ? '1 : bin_ext[BIN_WIDTH-1:0];
          ovf_r    <= ovf;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.binary   = binary_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
  assign dbg_state    = state;

`ifdef BCD_RANGE_CHECK_EN
  assign bus.error = error_r;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_binary.sv
// Table-driven bench for bcd_binary: latency, saturation, ignored start, mid-run reset
// and (with BCD_RANGE_CHECK_EN) digit range flagging.
module tb_bcd_binary;
  import bcd_binary_pkg::*;

  localparam int DIGITS    = 3;
  localparam int BIN_WIDTH = 8;
  localparam int BW        = 4 * DIGITS;
  localparam int DONE_EDGE = BW + 1;
  localparam int BUSY_CYC  = BW + 2;

  typedef struct {
    logic [BW-1:0]        bcd;
    logic [BIN_WIDTH-1:0] bin;
    logic                 ovf;
    logic                 err;
    string                name;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  int errors = 0;
  int checks = 0;
  logic [BIN_WIDTH-1:0] exp_q[$];

  bcd_binary_if #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) bus_if ();

  bcd_binary #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: start is high for exactly the edge that accepts it (edge 0)
  task automatic pulse_start(input logic [BW-1:0] bcd);
    @(negedge clk);
    bus_if.bcd_in = bcd;
    bus_if.start  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start  = 1'b0;
  endtask

  task automatic run_vec(input logic [BW-1:0] bcd, input logic [BIN_WIDTH-1:0] eb,
                         input logic eo, input logic ee, input string name);
    int done_edge, done_cnt, busy_cyc;
    logic [BIN_WIDTH-1:0] got_b, exp_b;
    logic got_o, got_e;
    done_edge = -1; done_cnt = 0; busy_cyc = 0;
    got_b = '0; got_o = 1'b0; got_e = 1'b0;
    exp_q.push_back(eb);
    pulse_start(bcd);
    check({name, "_busy_e0"}, 32'(bus_if.busy), 32'd1);
    if (bus_if.busy) busy_cyc++;
    for (int e = 1; e <= BUSY_CYC + 2; e++) begin
      @(posedge clk);
      #1;
      if (bus_if.busy) busy_cyc++;
      if (bus_if.done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          got_b = bus_if.binary;
          got_o = bus_if.overflow;
          got_e = bus_if.error;
        end
      end
    end
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({name, "_done_edge"}, 32'(done_edge), 32'(DONE_EDGE));
    check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(BUSY_CYC));
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({name, "_binary"}, 32'(got_b), 32'(exp_b));
    check({name, "_overflow"}, 32'(got_o), 32'(eo));
    check({name, "_error"}, 32'(got_e), 32'(ee));
    check({name, "_binary_held"}, 32'(bus_if.binary), 32'(exp_b));
  endtask

  initial begin
    vec_t vecs[9];
    int done_cnt, done_edge;
    logic [BIN_WIDTH-1:0] got_b;

    vecs[0] = '{12'h255, 8'd255, 1'b0, 1'b0, "v255"};
    vecs[1] = '{12'h128, 8'd128, 1'b0, 1'b0, "v128"};
    vecs[2] = '{12'h000, 8'd0,   1'b0, 1'b0, "v000"};
    vecs[3] = '{12'h009, 8'd9,   1'b0, 1'b0, "v009"};
    vecs[4] = '{12'h090, 8'd90,  1'b0, 1'b0, "v090"};
    vecs[5] = '{12'h100, 8'd100, 1'b0, 1'b0, "v100"};
    vecs[6] = '{12'h187, 8'd187, 1'b0, 1'b0, "v187"};
    vecs[7] = '{12'h256, 8'd255, 1'b1, 1'b0, "v256_sat"};
    vecs[8] = '{12'h999, 8'd255, 1'b1, 1'b0, "v999_sat"};

    rst_n = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.bcd_in = '0;
    #12;
    check("rst_binary", 32'(bus_if.binary), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_overflow", 32'(bus_if.overflow), 32'd0);
    check("rst_error", 32'(bus_if.error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i].bcd, vecs[i].bin, vecs[i].ovf, vecs[i].err, vecs[i].name);

    // reset in the middle of a conversion; overflow is still high from 999
    pulse_start(12'h987);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    check("mid_rst_done", 32'(bus_if.done), 32'd0);
    check("mid_rst_binary", 32'(bus_if.binary), 32'd0);
    check("mid_rst_overflow", 32'(bus_if.overflow), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    done_cnt = 0;
    repeat (BUSY_CYC) begin
      @(posedge clk);
      #1;
      if (bus_if.done) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(12'h042, 8'd42, 1'b0, 1'b0, "after_rst_042");

    // start while busy is dropped and input changes after acceptance are ignored
    exp_q.push_back(8'd123);
    pulse_start(12'h123);
    done_cnt = 0; done_edge = -1; got_b = '0;
    for (int e = 1; e <= 2 * BUSY_CYC; e++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          got_b = bus_if.binary;
        end
      end
      if (e == 1) bus_if.bcd_in = 12'h777;
      if (e == 3) begin
        bus_if.bcd_in = 12'h456;
        bus_if.start  = 1'b1;
      end
      if (e == 4) bus_if.start = 1'b0;
    end
    check("ign_done_count", 32'(done_cnt), 32'd1);
    check("ign_done_edge", 32'(done_edge), 32'(DONE_EDGE));
    check("ign_binary", 32'(got_b), 32'(exp_q.size() > 0 ? exp_q.pop_front() : 8'd0));
    check("ign_idle_busy", 32'(bus_if.busy), 32'd0);

`ifdef BCD_RANGE_CHECK_EN
    run_vec(12'h0A5, 8'd0, 1'b0, 1'b1, "range_tens_a");
    run_vec(12'h042, 8'd42, 1'b0, 1'b0, "range_clear");
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
